// File: rtl/wave_capture.sv
// wave_capture: writer side of a double-buffered 512-entry waveform RAM.
// Waits for a rising crossing of TRIG_LEVEL, then stores 256 consecutive
// samples as 8-bit screen rows into the buffer half the display is not
// reading. After the last sample it waits for the display's idle (blanking)
// window and flips read_index so the display picks up the new capture.
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   sample_ready      one-cycle strobe, new_sample_in valid
//   new_sample_in     signed audio sample, SAMPLE_W bits
//   wave_display_idle display is not reading the RAM (vblank)
//   write_address     RAM write address {~read_index, count}
//   write_enable      RAM write strobe, one cycle per stored sample
//   write_sample      screen row, 0 = top, 255 = bottom
//   read_index        buffer half the display reads
module wave_capture #(
  parameter int SAMPLE_W   = 16,
  parameter int ADDR_W     = 8,
  parameter int TRIG_LEVEL = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W:0]     write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  localparam logic signed [SAMPLE_W-1:0] TRIG_S = SAMPLE_W'(TRIG_LEVEL);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      state_n;
  logic [ADDR_W-1:0]           count_r;
  logic [ADDR_W-1:0]           count_n;
  logic signed [SAMPLE_W-1:0]  prev_sample_r;
  logic signed [SAMPLE_W-1:0]  sample_s;
  logic                        trigger_s;
  logic                        write_s;
  logic                        flip_s;

  // Top byte of the sample, inverted magnitude bits so +max lands on row 0.
  function automatic logic [7:0] row_map(input logic [SAMPLE_W-1:0] smp);
    logic [7:0] top;
    top = smp[SAMPLE_W-1 -: 8];
    return {top[7], ~top[6:0]};
  endfunction

  assign sample_s  = new_sample_in;
  assign trigger_s = sample_ready && (prev_sample_r < TRIG_S) && (sample_s >= TRIG_S);

  // Next-state, write request and buffer-flip decode.
  always_comb begin
    state_n = state_r;
    count_n = count_r;
    write_s = 1'b0;
    flip_s  = 1'b0;
    case (state_r)
      S_ARMED: begin
        if (trigger_s) begin
          write_s = 1'b1;
          count_n = ADDR_W'(1);
          state_n = S_ACTIVE;
        end else begin
          count_n = '0;
        end
      end
      S_ACTIVE: begin
        if (sample_ready) begin
          write_s = 1'b1;
          count_n = count_r + ADDR_W'(1);
          if (count_r == {ADDR_W{1'b1}}) begin
            state_n = S_WAIT;
          end else begin
            state_n = S_ACTIVE;
          end
        end else begin
          state_n = S_ACTIVE;
        end
      end
      S_WAIT: begin
        // A sample arriving with idle is only remembered, never stored.
        if (wave_display_idle) begin
          flip_s  = 1'b1;
          state_n = S_ARMED;
        end else begin
          state_n = S_WAIT;
        end
      end
      default: begin
        state_n = S_ARMED;
        count_n = '0;
      end
    endcase
  end

  // Control state, sample history and buffer selection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_ARMED;
      count_r       <= '0;
      prev_sample_r <= '0;
      read_index    <= 1'b0;
    end else begin
      state_r    <= state_n;
      count_r    <= count_n;
      read_index <= read_index ^ flip_s;
      if (sample_ready) begin
        prev_sample_r <= sample_s;
      end
    end
  end

  // Registered RAM write port; address/data hold between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= 8'h00;
    end else begin
      write_enable <= write_s;
      if (write_s) begin
        write_address <= {~read_index, count_r};
        write_sample  <= row_map(new_sample_in);
      end
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed scenarios plus random
// traffic compared against a capture model kept in terms of "samples taken
// so far in this capture".
module tb_wave_capture;

  logic        clk;
  logic        reset_n;
  logic        sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int total = 0;
  int bad   = 0;

  // model: taken = 0 armed, 1..255 capturing, 256 waiting for idle
  int m_taken;
  bit m_ri;
  int m_prev;
  int m_writes;

  wave_capture #(.SAMPLE_W(16), .ADDR_W(8), .TRIG_LEVEL(0)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .sample_ready      (sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_taken = 0;
    m_ri    = 1'b0;
    m_prev  = 0;
  endtask

  // Drive one cycle of inputs, advance the model, check outputs after the edge.
  task automatic step(input bit sr, input int smp, input bit idle);
    bit ew;
    int ea;
    int ed;
    sample_ready      = sr;
    new_sample_in     = smp[15:0];
    wave_display_idle = idle;
    ew = 1'b0;
    ea = 0;
    ed = 0;
    if (m_taken == 256) begin
      if (idle) begin
        m_ri    = ~m_ri;
        m_taken = 0;
      end
    end else if (sr && (m_taken > 0 || (m_prev < 0 && smp >= 0))) begin
      ew = 1'b1;
      ea = (m_ri ? 0 : 256) + m_taken;
      ed = 127 - (smp >>> 8);
      m_taken++;
    end
    if (sr) m_prev = smp;
    @(posedge clk);
    #1;
    if (ew) m_writes++;
    check_eq("we", write_enable, ew);
    if (ew) begin
      check_eq("addr", write_address, ea);
      check_eq("data", write_sample, ed);
    end
    check_eq("ri", read_index, m_ri);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, write_enable, 1'b0);
    check_eq({tag, "_addr"}, write_address, 9'h000);
    check_eq({tag, "_data"}, write_sample, 8'h00);
    check_eq({tag, "_ri"}, read_index, 1'b0);
  endtask

  initial begin
    int guard;
    reset_n           = 1'b0;
    sample_ready      = 1'b0;
    new_sample_in     = 16'h0000;
    wave_display_idle = 1'b0;
    model_reset();
    m_writes = 0;

    // 1. reset held with activity on the inputs
    for (int i = 0; i < 4; i++) begin
      sample_ready  = i[0];
      new_sample_in = (i == 1) ? 16'hFFFB : 16'h0003;
      @(posedge clk);
      #1;
      check_all_zero("rst");
    end
    sample_ready = 1'b0;
    reset_n      = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rel");

    // 2. trigger on -5 -> +3
    step(1'b1, -5, 1'b0);
    step(1'b1, 3, 1'b0);
    check_eq("t2_addr", write_address, 9'h100);
    check_eq("t2_data", write_sample, 8'h7F);

    // 3. rest of the capture with gaps, then wait and flip
    guard = 0;
    while (m_taken < 256 && guard < 2000) begin
      step($urandom_range(0, 2) != 0, rnd_sample(), 1'b0);
      guard++;
    end
    check_eq("t3_writes", m_writes, 256);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_sample(), 1'b0);
    check_eq("t3_ri_hold", read_index, 1'b0);
    step(1'b0, 0, 1'b1);
    check_eq("t3_ri_flip", read_index, 1'b1);

    // 4. row mapping; the new capture lands in the lower half
    step(1'b1, -1, 1'b0);
    step(1'b1, 32512, 1'b0);
    check_eq("t4_addr", write_address, 9'h000);
    check_eq("t4_7f", write_sample, 8'h00);
    step(1'b1, -32768, 1'b0);
    check_eq("t4_80", write_sample, 8'hFF);
    step(1'b1, -256, 1'b0);
    check_eq("t4_ff", write_sample, 8'h80);

    // 5. idle held through the capture; flip only once it is done
    while (m_taken < 256) step(1'b1, rnd_sample(), 1'b1);
    check_eq("t5_last_addr", write_address, 9'h0FF);
    check_eq("t5_ri_hold", read_index, 1'b1);
    step(1'b1, 1000, 1'b1);
    check_eq("t5_nowrite", write_enable, 1'b0);
    check_eq("t5_ri_flip", read_index, 1'b0);
    step(1'b1, 5, 1'b0);

    // 6. reset in the middle of a capture
    step(1'b1, -10, 1'b0);
    step(1'b1, 10, 1'b0);
    for (int i = 0; i < 99; i++) step(1'b1, rnd_sample(), 1'b0);
    check_eq("t6_cnt", write_address, 9'h163);
    reset_n = 1'b0;
    #1;
    check_eq("t6_we", write_enable, 1'b0);
    check_eq("t6_ri", read_index, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, -3, 1'b0);
    step(1'b1, 3, 1'b0);
    check_eq("t6_rearm", write_address, 9'h100);

    // random traffic, small samples so crossings are frequent
    for (int i = 0; i < 4000; i++) begin
      int smp;
      smp = ($urandom_range(0, 3) == 0) ? rnd_sample() : int'($urandom_range(0, 2000)) - 1000;
      step($urandom_range(0, 1) == 1, smp, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
